// File: rtl/cdb_arbiter_pkg.sv
// Shared core types for the writeback/CDB path: result packet layout and
// the core-level sizes the CDB arbiter derives its widths from.
package cdb_arbiter_pkg;

    localparam int ISSUE_WIDTH = 2;
    localparam int PREGS       = 64;
    localparam int ROB_ENTRIES = 32;
    localparam int CDB_NSRC    = 3;

    localparam int TAG_W = $clog2(PREGS);
    localparam int ROB_W = $clog2(ROB_ENTRIES);

    typedef logic [TAG_W-1:0] preg_tag_t;

    typedef struct packed {
        preg_tag_t        tag;
        logic [31:0]      value;
        logic [ROB_W-1:0] rob;
        logic             exc;
    } cdb_pkt_t;

    function automatic cdb_pkt_t make_pkt(
        input preg_tag_t        tag,
        input logic [31:0]      value,
        input logic [ROB_W-1:0] rob,
        input logic             exc
    );
        cdb_pkt_t p;
        p.tag   = tag;
        p.value = value;
        p.rob   = rob;
        p.exc   = exc;
        return p;
    endfunction

endpackage

// File: rtl/cdb_arbiter_mp_fifo.sv
// Multi-port circular buffer of CDB packets: NW writes at caller-supplied
// offsets from wr_ptr, NR peek ports at rd_ptr.. with a thermometer dequeue.
module mp_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int NW    = 3,
    parameter  int NR    = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH+1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [NW-1:0]              wr_en,
    input  logic [NW-1:0][PTR_W-1:0]   wr_off,
    input  cdb_pkt_t [NW-1:0]          wr_data,
    input  logic [NR-1:0]              rd_en,
    output cdb_pkt_t [NR-1:0]          rd_data,
    output logic [CNT_W-1:0]           count
);

    cdb_pkt_t         mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] n_wr, n_rd;
    logic [NW-1:0][PTR_W-1:0] wr_addr;
    logic [NR-1:0][PTR_W-1:0] rd_addr;

    genvar gi;
    generate
        for (gi = 0; gi < NW; gi++) begin : g_waddr
            assign wr_addr[gi] = wr_ptr_q + wr_off[gi];
        end
        for (gi = 0; gi < NR; gi++) begin : g_rport
            assign rd_addr[gi] = rd_ptr_q + PTR_W'(gi);
            assign rd_data[gi] = mem_q[rd_addr[gi]];
        end
    endgenerate

    always_comb begin
        n_wr = '0;
        n_rd = '0;
        for (int s = 0; s < NW; s++) begin
            n_wr = n_wr + CNT_W'(wr_en[s]);
        end
        for (int r = 0; r < NR; r++) begin
            n_rd = n_rd + CNT_W'(rd_en[r]);
        end
        wr_ptr_d = wr_ptr_q + n_wr[PTR_W-1:0];
        rd_ptr_d = rd_ptr_q + n_rd[PTR_W-1:0];
        count_d  = count_q + n_wr - n_rd;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Writes only ever land in free slots, so they never collide with peeks.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (!flush) begin
            for (int s = 0; s < NW; s++) begin
                if (wr_en[s]) begin
                    mem_q[wr_addr[s]] <= wr_data[s];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            assert (int'(n_rd) <= int'(count_q));
            assert (int'(count_q) + int'(n_wr) - int'(n_rd) <= DEPTH);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Writeback collector: compacts ALU0/ALU1/BR results into a shared buffer and
// broadcasts up to CDB_W of the oldest entries per cycle on registered CDB slots.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int CDB_W = ISSUE_WIDTH,
    parameter  int NSRC  = CDB_NSRC,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH+1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NSRC-1:0]             res_valid,
    input  logic [NSRC-1:0][TAG_W-1:0]  res_tag,
    input  logic [NSRC-1:0][31:0]       res_value,
    input  logic [NSRC-1:0][ROB_W-1:0]  res_rob,
    input  logic [NSRC-1:0]             res_exc,
    output logic                        res_ready,
    input  logic                        flush,
    output logic [CDB_W-1:0]            cdb_valid,
    output logic [CDB_W-1:0][TAG_W-1:0] cdb_tag,
    output logic [CDB_W-1:0][31:0]      cdb_value,
    output logic [CDB_W-1:0][ROB_W-1:0] cdb_rob,
    output logic [CDB_W-1:0]            cdb_exc,
    output logic [CNT_W-1:0]            occupancy
);

    logic [NSRC-1:0]             acc;
    logic [NSRC-1:0][PTR_W-1:0]  wr_off;
    cdb_pkt_t [NSRC-1:0]         src_pkt;
    cdb_pkt_t [CDB_W-1:0]        head_pkt;
    logic [CDB_W-1:0]            deq;
    logic [CNT_W-1:0]            count;

    cdb_pkt_t [CDB_W-1:0]        slot_q, slot_d;
    logic [CDB_W-1:0]            slot_vld_q, slot_vld_d;

    // Whole-group accept: the buffer must have room for every source at once,
    // judged from the registered count only.
    assign res_ready = (count <= CNT_W'(DEPTH - NSRC));
    assign acc       = res_valid & {NSRC{res_ready & ~flush}};

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            assign src_pkt[gi] = make_pkt(res_tag[gi], res_value[gi], res_rob[gi], res_exc[gi]);
        end
        for (gi = 0; gi < CDB_W; gi++) begin : g_deq
            assign deq[gi] = (count > CNT_W'(gi));
        end
    endgenerate

    // Each accepted source lands after all accepted lower-numbered sources.
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            wr_off[s] = '0;
            for (int j = 0; j < s; j++) begin
                wr_off[s] = wr_off[s] + PTR_W'(acc[j]);
            end
        end
    end

    mp_fifo #(
        .DEPTH (DEPTH),
        .NW    (NSRC),
        .NR    (CDB_W)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .wr_en   (acc),
        .wr_off  (wr_off),
        .wr_data (src_pkt),
        .rd_en   (deq),
        .rd_data (head_pkt),
        .count   (count)
    );

    always_comb begin
        for (int b = 0; b < CDB_W; b++) begin
            slot_vld_d[b] = deq[b];
            slot_d[b]     = deq[b] ? head_pkt[b] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            slot_vld_q <= '0;
            slot_q     <= '0;
        end else begin
            slot_vld_q <= slot_vld_d;
            slot_q     <= slot_d;
        end
    end

    generate
        for (gi = 0; gi < CDB_W; gi++) begin : g_cdb
            assign cdb_valid[gi] = slot_vld_q[gi];
            assign cdb_tag[gi]   = slot_q[gi].tag;
            assign cdb_value[gi] = slot_q[gi].value;
            assign cdb_rob[gi]   = slot_q[gi].rob;
            assign cdb_exc[gi]   = slot_q[gi].exc;
        end
    endgenerate

    assign occupancy = count;

endmodule
